// File: rtl/echo_dispatch_rr.sv
// Round-robin echo frame dispatcher for N distance lanes, with per-lane watchdog,
// drop accounting and in-order or completion-order result collection.
module echo_dispatch_rr #(
    parameter int unsigned LANES    = 4,
    parameter int unsigned DATA_W   = 400,
    parameter int unsigned RES_W    = 120,
    parameter int unsigned TIMEOUT  = 1024,
    parameter int unsigned IN_ORDER = 1,
    parameter int unsigned LID_W    = $clog2(LANES)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    frame_en,
    input  logic [DATA_W-1:0]       frame_data,
    input  logic [LANES-1:0]        lane_mask,
    output logic [LANES-1:0]        lane_start,
    output logic [LANES*DATA_W-1:0] lane_data,
    input  logic [LANES-1:0]        lane_valid,
    input  logic [LANES*RES_W-1:0]  lane_result,
    output logic                    res_valid,
    output logic [RES_W-1:0]        res_data,
    output logic [LID_W-1:0]        res_lane,
    output logic                    res_timeout,
    output logic [LANES-1:0]        busy_map,
    output logic                    drop_pulse,
    output logic [15:0]             drop_cnt
);

    localparam int unsigned CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int unsigned FCNT_W = $clog2(LANES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
    localparam logic [LID_W-1:0] LANE_MAX = LID_W'(LANES - 1);

    typedef enum logic [1:0] {
        L_IDLE = 2'd0,
        L_RUN  = 2'd1,
        L_DONE = 2'd2
    } lane_st_e;

    lane_st_e           st      [LANES];
    lane_st_e           st_n    [LANES];
    logic [RES_W-1:0]   hold    [LANES];
    logic [LANES-1:0]   tflag;
    logic [CNT_W-1:0]   wd_cnt  [LANES];

    logic [LID_W-1:0]   ptr;
    logic [LID_W-1:0]   fifo_mem [LANES];
    logic [LID_W-1:0]   fifo_rd;
    logic [LID_W-1:0]   fifo_wr;
    logic [FCNT_W-1:0]  fifo_cnt;

    logic [LANES-1:0]   done_c;
    logic [RES_W-1:0]   eff_res [LANES];
    logic [LANES-1:0]   eff_to;
    logic               disp_hit;
    logic [LID_W-1:0]   disp_idx;
    logic [LID_W-1:0]   cand;
    logic               emit_hit;
    logic [LID_W-1:0]   emit_idx;
    logic [LID_W-1:0]   head_lane;

    function automatic logic [LID_W-1:0] wrap_inc(input logic [LID_W-1:0] v);
        return (v == LANE_MAX) ? '0 : v + 1'b1;
    endfunction

    // Completion this cycle, with lane_valid taking priority over the watchdog
    always_comb begin
        for (int i = 0; i < int'(LANES); i++) begin
            done_c[i]  = 1'b0;
            eff_res[i] = hold[i];
            eff_to[i]  = tflag[i];
            if (st[i] == L_DONE) begin
                done_c[i] = 1'b1;
            end else if (st[i] == L_RUN) begin
                if (lane_valid[i]) begin
                    done_c[i]  = 1'b1;
                    eff_res[i] = lane_result[i*RES_W +: RES_W];
                    eff_to[i]  = 1'b0;
                end else if ((TIMEOUT != 0) && (wd_cnt[i] == CNT_MAX)) begin
                    done_c[i]  = 1'b1;
                    eff_res[i] = '0;
                    eff_to[i]  = 1'b1;
                end
            end
        end
    end

    // Dispatch search from the rotation pointer; sees pre-emission lane state
    always_comb begin
        disp_hit = 1'b0;
        disp_idx = ptr;
        cand     = ptr;
        for (int k = 0; k < int'(LANES); k++) begin
            cand = LID_W'((32'(ptr) + 32'(k)) % LANES);
            if (!disp_hit && frame_en && lane_mask[cand] && (st[cand] == L_IDLE)) begin
                disp_hit = 1'b1;
                disp_idx = cand;
            end
        end
    end

    // Emission select: FIFO head in order mode, lowest-index done lane otherwise
    always_comb begin
        head_lane = fifo_mem[fifo_rd];
        emit_hit  = 1'b0;
        emit_idx  = '0;
        if (IN_ORDER != 0) begin
            if ((fifo_cnt != '0) && done_c[head_lane]) begin
                emit_hit = 1'b1;
                emit_idx = head_lane;
            end
        end else begin
            for (int i = int'(LANES) - 1; i >= 0; i--) begin
                if (done_c[i]) begin
                    emit_hit = 1'b1;
                    emit_idx = LID_W'(i);
                end
            end
        end
    end

    // Lane next state
    always_comb begin
        for (int i = 0; i < int'(LANES); i++) begin
            st_n[i] = st[i];
            case (st[i])
                L_IDLE: if (disp_hit && (disp_idx == LID_W'(i))) st_n[i] = L_RUN;
                L_RUN: begin
                    if (done_c[i]) begin
                        st_n[i] = (emit_hit && (emit_idx == LID_W'(i))) ? L_IDLE : L_DONE;
                    end
                end
                L_DONE: if (emit_hit && (emit_idx == LID_W'(i))) st_n[i] = L_IDLE;
                default: st_n[i] = L_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr         <= '0;
            lane_start  <= '0;
            lane_data   <= '0;
            res_valid   <= 1'b0;
            res_data    <= '0;
            res_lane    <= '0;
            res_timeout <= 1'b0;
            busy_map    <= '0;
            drop_pulse  <= 1'b0;
            drop_cnt    <= '0;
            tflag       <= '0;
            fifo_rd     <= '0;
            fifo_wr     <= '0;
            fifo_cnt    <= '0;
            for (int i = 0; i < int'(LANES); i++) begin
                st[i]       <= L_IDLE;
                hold[i]     <= '0;
                wd_cnt[i]   <= '0;
                fifo_mem[i] <= '0;
            end
        end else begin
            lane_start <= '0;
            res_valid  <= 1'b0;
            drop_pulse <= 1'b0;

            for (int i = 0; i < int'(LANES); i++) begin
                st[i]       <= st_n[i];
                busy_map[i] <= (st_n[i] != L_IDLE);
                if ((st[i] == L_IDLE) && (st_n[i] == L_RUN)) begin
                    lane_start[i]                 <= 1'b1;
                    lane_data[i*DATA_W +: DATA_W] <= frame_data;
                    wd_cnt[i]                     <= '0;
                end else if ((st[i] == L_RUN) && (wd_cnt[i] != CNT_MAX)) begin
                    wd_cnt[i] <= wd_cnt[i] + 1'b1;
                end
                if ((st[i] == L_RUN) && (st_n[i] == L_DONE)) begin
                    hold[i]  <= eff_res[i];
                    tflag[i] <= eff_to[i];
                end
            end

            if (disp_hit) begin
                ptr <= wrap_inc(disp_idx);
            end else if (frame_en) begin
                drop_pulse <= 1'b1;
                if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
            end

            if (emit_hit) begin
                res_valid   <= 1'b1;
                res_data    <= eff_res[emit_idx];
                res_lane    <= emit_idx;
                res_timeout <= eff_to[emit_idx];
            end

            // Order FIFO holds one entry per busy lane, so it never overflows
            if (IN_ORDER != 0) begin
                if (disp_hit) begin
                    fifo_mem[fifo_wr] <= disp_idx;
                    fifo_wr           <= wrap_inc(fifo_wr);
                end
                if (emit_hit) fifo_rd <= wrap_inc(fifo_rd);
                if (disp_hit && !emit_hit) begin
                    fifo_cnt <= fifo_cnt + 1'b1;
                end else if (!disp_hit && emit_hit) begin
                    fifo_cnt <= fifo_cnt - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_echo_dispatch_rr.sv
// Self-checking bench for echo_dispatch_rr: dispatch table plus scoreboarded result stream.
`timescale 1ns/1ps
module tb_echo_dispatch_rr;

    localparam int unsigned LANES   = 4;
    localparam int unsigned DATA_W  = 400;
    localparam int unsigned RES_W   = 120;
    localparam int unsigned TIMEOUT = 16;
    localparam int unsigned LID_W   = 2;
    localparam int unsigned W       = DATA_W;

    logic                    clk = 1'b0;
    logic                    rst = 1'b0;
    logic                    frame_en;
    logic [DATA_W-1:0]       frame_data;
    logic [LANES-1:0]        lane_mask;
    logic [LANES-1:0]        lane_start;
    logic [LANES*DATA_W-1:0] lane_data;
    logic [LANES-1:0]        lane_valid;
    logic [LANES*RES_W-1:0]  lane_result;
    logic                    res_valid;
    logic [RES_W-1:0]        res_data;
    logic [LID_W-1:0]        res_lane;
    logic                    res_timeout;
    logic [LANES-1:0]        busy_map;
    logic                    drop_pulse;
    logic [15:0]             drop_cnt;

    always #5 clk = ~clk;

    echo_dispatch_rr #(
        .LANES(LANES), .DATA_W(DATA_W), .RES_W(RES_W),
        .TIMEOUT(TIMEOUT), .IN_ORDER(1), .LID_W(LID_W)
    ) dut (
        .clk(clk), .rst(rst),
        .frame_en(frame_en), .frame_data(frame_data), .lane_mask(lane_mask),
        .lane_start(lane_start), .lane_data(lane_data),
        .lane_valid(lane_valid), .lane_result(lane_result),
        .res_valid(res_valid), .res_data(res_data), .res_lane(res_lane),
        .res_timeout(res_timeout), .busy_map(busy_map),
        .drop_pulse(drop_pulse), .drop_cnt(drop_cnt)
    );

    typedef struct {
        logic [LID_W-1:0] lane;
        logic [RES_W-1:0] data;
        logic             tmo;
    } exp_t;

    typedef struct {
        logic        en;
        logic [3:0]  mask;
        logic [3:0]  start;
        logic        drop;
        logic [3:0]  busy;
        logic [15:0] dcnt;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t vecs [9];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DATA_W-1:0] mkframe(input int s);
        logic [DATA_W-1:0] f;
        for (int j = 0; j < 25; j++) f[j*16 +: 16] = 16'(s * 97 + j * 13 + 5);
        return f;
    endfunction

    function automatic logic [RES_W-1:0] mkres(input int s);
        return {56'(s * 3 + 1), 64'(s * 1000003 + 7)};
    endfunction

    task automatic push_exp(input int ln, input logic [RES_W-1:0] d, input logic t);
        exp_t e;
        e.lane = LID_W'(ln);
        e.data = d;
        e.tmo  = t;
        sb.push_back(e);
    endtask

    task automatic strobe(input logic [DATA_W-1:0] d);
        frame_en   = 1'b1;
        frame_data = d;
        step();
        frame_en   = 1'b0;
    endtask

    task automatic respond(input int ln, input logic [RES_W-1:0] v);
        lane_valid                      = '0;
        lane_valid[ln]                  = 1'b1;
        lane_result[ln*RES_W +: RES_W]  = v;
        step();
        lane_valid = '0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
    endtask

    // Result stream checker against the scoreboard
    always @(negedge clk) begin
        if (rst && res_valid) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL res_unexpected: got lane=%0d tmo=%0b data=%0h expected no result",
                         res_lane, res_timeout, res_data);
            end else begin
                mon_e = sb.pop_front();
                chk("res_lane", W'(res_lane), W'(mon_e.lane));
                chk("res_data", W'(res_data), W'(mon_e.data));
                chk("res_timeout", W'(res_timeout), W'(mon_e.tmo));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        vecs[0] = '{1'b1, 4'b1010, 4'b0010, 1'b0, 4'b0010, 16'd0};
        vecs[1] = '{1'b1, 4'b1010, 4'b1000, 1'b0, 4'b1010, 16'd0};
        vecs[2] = '{1'b1, 4'b1010, 4'b0000, 1'b1, 4'b1010, 16'd1};
        vecs[3] = '{1'b1, 4'b1010, 4'b0000, 1'b1, 4'b1010, 16'd2};
        vecs[4] = '{1'b1, 4'b1010, 4'b0000, 1'b1, 4'b1010, 16'd3};
        vecs[5] = '{1'b1, 4'b1010, 4'b0000, 1'b1, 4'b1010, 16'd4};
        vecs[6] = '{1'b0, 4'b1010, 4'b0000, 1'b0, 4'b1010, 16'd4};
        vecs[7] = '{1'b1, 4'b0000, 4'b0000, 1'b1, 4'b1010, 16'd5};
        vecs[8] = '{1'b1, 4'b0101, 4'b0001, 1'b0, 4'b1011, 16'd5};

        frame_en    = 1'b0;
        frame_data  = '0;
        lane_mask   = '0;
        lane_valid  = '0;
        lane_result = '0;
        rst         = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_lane_start", W'(lane_start), W'(0));
        chk("rst_busy_map", W'(busy_map), W'(0));
        chk("rst_res_valid", W'(res_valid), W'(0));
        chk("rst_res_data", W'(res_data), W'(0));
        chk("rst_drop_cnt", W'(drop_cnt), W'(0));
        chk("rst_lane_data0", lane_data[0 +: DATA_W], W'(0));
        rst = 1'b1;
        step();

        // Round-robin through all four lanes, each answering five cycles after start
        lane_mask = 4'hF;
        for (int k = 0; k < 4; k++) begin
            strobe(mkframe(k));
            chk("t1_lane_start", W'(lane_start), W'(4'b0001 << k));
            chk("t1_lane_data", lane_data[k*DATA_W +: DATA_W], mkframe(k));
            repeat (4) step();
            push_exp(k, mkres(k), 1'b0);
            respond(k, mkres(k));
            chk("t1_busy_after_emit", W'(busy_map), W'(0));
            repeat (4) step();
        end

        // Out-of-order completion is reordered to dispatch order
        strobe(mkframe(10));
        strobe(mkframe(11));
        strobe(mkframe(12));
        chk("t2_lane_start", W'(lane_start), W'(4'b0100));
        push_exp(0, mkres(20), 1'b0);
        push_exp(1, mkres(21), 1'b0);
        push_exp(2, mkres(22), 1'b0);
        step();
        respond(2, mkres(22));
        chk("t2_lane2_held", W'(res_valid), W'(0));
        chk("t2_busy_held", W'(busy_map), W'(4'b0111));
        respond(0, mkres(20));
        respond(1, mkres(21));
        step();
        chk("t2_busy_clear", W'(busy_map), W'(0));
        step();

        // Masked dispatch and drop accounting; the lanes later time out in order
        do_reset();
        push_exp(1, '0, 1'b1);
        push_exp(3, '0, 1'b1);
        push_exp(0, '0, 1'b1);
        for (int i = 0; i < 9; i++) begin
            frame_en   = vecs[i].en;
            lane_mask  = vecs[i].mask;
            frame_data = mkframe(30 + i);
            step();
            chk("t3_lane_start", W'(lane_start), W'(vecs[i].start));
            chk("t3_drop_pulse", W'(drop_pulse), W'(vecs[i].drop));
            chk("t3_busy_map", W'(busy_map), W'(vecs[i].busy));
            chk("t3_drop_cnt", W'(drop_cnt), W'(vecs[i].dcnt));
        end
        frame_en = 1'b0;
        repeat (25) step();
        chk("t3_busy_final", W'(busy_map), W'(0));
        chk("t3_drop_cnt_final", W'(drop_cnt), W'(5));

        // Watchdog expiry: result exactly 17 cycles after lane_start
        lane_mask = 4'b0001;
        strobe(mkframe(40));
        chk("t4_lane_start", W'(lane_start), W'(4'b0001));
        push_exp(0, '0, 1'b1);
        for (int c = 1; c <= 17; c++) begin
            step();
            chk("t4_res_valid_timing", W'(res_valid), W'(c == 17));
        end
        chk("t4_busy_clear", W'(busy_map), W'(0));
        step();

        // lane_valid on the cycle the count reaches TIMEOUT wins over the watchdog
        strobe(mkframe(50));
        chk("t5_lane_start", W'(lane_start), W'(4'b0001));
        repeat (16) step();
        push_exp(0, mkres(50), 1'b0);
        respond(0, mkres(50));
        chk("t5_res_valid", W'(res_valid), W'(1));
        respond(2, mkres(51));
        repeat (3) step();
        chk("t5_idle_valid_ignored", W'(busy_map), W'(0));

        // Reset with three lanes running and one lane done
        lane_mask = 4'hF;
        strobe(mkframe(60));
        strobe(mkframe(61));
        strobe(mkframe(62));
        strobe(mkframe(63));
        chk("t6_lane_start", W'(lane_start), W'(4'b0001));
        respond(3, mkres(60));
        chk("t6_no_emit", W'(res_valid), W'(0));
        chk("t6_busy_all", W'(busy_map), W'(4'hF));
        #2;
        rst = 1'b0;
        #1;
        chk("t6_rst_busy", W'(busy_map), W'(0));
        chk("t6_rst_lane_data", lane_data[3*DATA_W +: DATA_W], W'(0));
        chk("t6_rst_drop_cnt", W'(drop_cnt), W'(0));
        chk("t6_rst_res_valid", W'(res_valid), W'(0));
        step();
        step();
        rst = 1'b1;
        repeat (20) step();
        strobe(mkframe(70));
        chk("t6_post_rst_lane", W'(lane_start), W'(4'b0001));
        push_exp(0, '0, 1'b1);
        repeat (20) step();
        chk("sb_drained", W'(sb.size()), W'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
